// File: rtl/vga_sync_rx.sv
// VGA sync receiver: measures line/frame timing, locks after clean frames, tracks x/y and captures one probed pixel.
// Optional error counter enabled by defining VGA_SYNC_RX_ERR_CNT_EN.
module vga_sync_rx #(
    parameter int H_TOT       = 800,
    parameter int V_TOT       = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync_n,
    input  logic        vsync_n,
    input  logic        active,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        locked,
    output logic        line_err,
    output logic        frame_err,
    output logic        frame_start,
    output logic [15:0] probe_pixel,
    output logic        probe_valid,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        hs_q, vs_q, act_q;
    logic [10:0] h_meas_q, h_meas_d;
    logic [9:0]  v_meas_q, v_meas_d;
    logic        h_seen_q, h_seen_d;
    logic        v_seen_q, v_seen_d;
    logic        dirty_q, dirty_d;
    logic [7:0]  good_q, good_d;
    logic        locked_q, locked_d;
    logic        line_err_q, line_err_d;
    logic        frame_err_q, frame_err_d;
    logic        frame_start_q, frame_start_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [15:0] probe_pixel_q, probe_pixel_d;
    logic        probe_valid_q, probe_valid_d;

    logic        hs_fall, vs_fall, act_fall;
    logic [11:0] h_meas_inc;
    logic [9:0]  v_meas_eff;
    logic        line_bad, frame_bad, clean, resync, cap;

    always_comb begin
        hs_fall  = hs_q & ~hsync_n;
        vs_fall  = vs_q & ~vsync_n;
        act_fall = act_q & ~active;

        h_meas_inc = {1'b0, h_meas_q} + 12'd1;
        line_bad   = hs_fall & h_seen_q & (h_meas_inc != 12'(H_TOT));

        // an hsync fall coinciding with the vsync fall belongs to the frame that is ending
        v_meas_eff = (hs_fall && (v_meas_q != 10'h3FF)) ? v_meas_q + 10'd1 : v_meas_q;
        frame_bad  = vs_fall & v_seen_q & (v_meas_eff != 10'(V_TOT));

        clean  = ~dirty_q & ~line_bad & ~frame_bad;
        resync = (state_q == LOCKED) & (line_err_q | frame_err_q);

        h_meas_d = h_meas_q;
        if (hs_fall) begin
            h_meas_d = '0;
        end else if (h_meas_q != 11'h7FF) begin
            h_meas_d = h_meas_q + 11'd1;
        end
        h_seen_d = resync ? 1'b0 : (h_seen_q | hs_fall);

        v_meas_d = vs_fall ? '0 : v_meas_eff;
        v_seen_d = resync ? 1'b0 : (v_seen_q | vs_fall);
        dirty_d  = vs_fall ? 1'b0 : (dirty_q | line_bad);

        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            SEARCH: begin
                if (vs_fall) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            end
            ACQUIRE: begin
                if (vs_fall) begin
                    if (clean) begin
                        good_d = good_q + 8'd1;
                        if (good_d == 8'(LOCK_FRAMES)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (line_err_q || frame_err_q) begin
                    state_d = SEARCH;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = SEARCH;
                good_d  = '0;
            end
        endcase

        locked_d      = (state_d == LOCKED);
        line_err_d    = line_bad;
        frame_err_d   = frame_bad;
        frame_start_d = vs_fall;

        x_d = x_q;
        if (hs_fall) begin
            x_d = '0;
        end else if (active && (x_q != 10'h3FF)) begin
            x_d = x_q + 10'd1;
        end

        y_d = y_q;
        if (vs_fall) begin
            y_d = '0;
        end else if (act_fall && (y_q != 10'h3FF)) begin
            y_d = y_q + 10'd1;
        end

        cap           = locked_q & active & (x_q == probe_x) & (y_q == probe_y);
        probe_pixel_d = cap ? {green, red} : probe_pixel_q;
        probe_valid_d = cap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SEARCH;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            act_q         <= 1'b0;
            h_meas_q      <= '0;
            v_meas_q      <= '0;
            h_seen_q      <= 1'b0;
            v_seen_q      <= 1'b0;
            dirty_q       <= 1'b0;
            good_q        <= '0;
            locked_q      <= 1'b0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_start_q <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            probe_pixel_q <= '0;
            probe_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_q          <= hsync_n;
            vs_q          <= vsync_n;
            act_q         <= active;
            h_meas_q      <= h_meas_d;
            v_meas_q      <= v_meas_d;
            h_seen_q      <= h_seen_d;
            v_seen_q      <= v_seen_d;
            dirty_q       <= dirty_d;
            good_q        <= good_d;
            locked_q      <= locked_d;
            line_err_q    <= line_err_d;
            frame_err_q   <= frame_err_d;
            frame_start_q <= frame_start_d;
            x_q           <= x_d;
            y_q           <= y_d;
            probe_pixel_q <= probe_pixel_d;
            probe_valid_q <= probe_valid_d;
        end
    end

`ifdef VGA_SYNC_RX_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [16:0] err_sum;

    always_comb begin
        err_sum   = {1'b0, err_cnt_q} + 17'(line_err_q) + 17'(frame_err_q);
        err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign x           = x_q;
    assign y           = y_q;
    assign locked      = locked_q;
    assign line_err    = line_err_q;
    assign frame_err   = frame_err_q;
    assign frame_start = frame_start_q;
    assign probe_pixel = probe_pixel_q;
    assign probe_valid = probe_valid_q;

endmodule
